// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one instruction word at a time from memory,
// holds it for the decoder, and sequences the PC on advance (sequential or branch).
module instruction_fetch #(
  parameter int                  DATA_WIDTH        = 32,
  parameter int                  INSTRUCTION_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int                  TIMEOUT_CYCLES    = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         advance,
  input  logic                         should_take_branch,
  input  logic [DATA_WIDTH-1:0]        branch_target,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  input  logic                         mem_ready,
  output logic                         mem_read,
  output logic [DATA_WIDTH-1:0]        mem_address,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instruction_valid,
  output logic [DATA_WIDTH-1:0]        pc,
  output logic [DATA_WIDTH-1:0]        pc_next_seq,
  output logic                         fetch_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT,
    HOLD
  } state_t;

  state_t                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic                         valid_q, valid_d;
  logic                         error_q, error_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    mem_read = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQUEST;
      end

      REQUEST: begin
        mem_read = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT;
      end

      WAIT: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          instr_d = mem_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          // Counter saturates at the timeout; the error flag is sticky until reset.
          if (cnt_q != TIMEOUT) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d == TIMEOUT) begin
            error_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (enable && advance) begin
          pc_d    = should_take_branch ? branch_target : pc_q + 1'b1;
          valid_d = 1'b0;
          state_d = REQUEST;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_address       = pc_q;
  assign pc                = pc_q;
  assign pc_next_seq       = pc_q + 1'b1;
  assign Instruction       = instr_q;
  assign instruction_valid = valid_q;
  assign fetch_error       = error_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: randomized fetch/hold transactions
// checked cycle by cycle against a transaction-level model of PC, instruction and flags.
module tb_instruction_fetch;

  localparam int              DW = 32;
  localparam int              IW = 16;
  localparam int              TO = 255;
  localparam logic [DW-1:0]   RV = '0;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          advance;
  logic          shouldTakeBranch;
  logic [DW-1:0] branchTarget;
  logic [IW-1:0] memData;
  logic          memReady;
  logic          memRead;
  logic [DW-1:0] memAddress;
  logic [IW-1:0] instruction;
  logic          instructionValid;
  logic [DW-1:0] pcOut;
  logic [DW-1:0] pcNextSeq;
  logic          fetchError;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  logic [DW-1:0] expPc;
  logic [IW-1:0] expInstr;
  logic          expValid;
  logic          expErr;
  int            idleWait;

  instruction_fetch #(
    .DATA_WIDTH(DW),
    .INSTRUCTION_WIDTH(IW),
    .RESET_VECTOR(RV),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .advance(advance),
    .should_take_branch(shouldTakeBranch),
    .branch_target(branchTarget),
    .mem_data(memData),
    .mem_ready(memReady),
    .mem_read(memRead),
    .mem_address(memAddress),
    .Instruction(instruction),
    .instruction_valid(instructionValid),
    .pc(pcOut),
    .pc_next_seq(pcNextSeq),
    .fetch_error(fetchError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string where, input logic expRead);
    logic [DW-1:0] nextSeq;
    nextSeq = expPc + 1'b1;
    checkOutput({where, ":mem_read"}, 64'(memRead), 64'(expRead));
    checkOutput({where, ":pc"}, 64'(pcOut), 64'(expPc));
    checkOutput({where, ":mem_address"}, 64'(memAddress), 64'(expPc));
    checkOutput({where, ":pc_next_seq"}, 64'(pcNextSeq), 64'(nextSeq));
    checkOutput({where, ":instruction"}, 64'(instruction), 64'(expInstr));
    checkOutput({where, ":valid"}, 64'(instructionValid), 64'(expValid));
    checkOutput({where, ":fetch_error"}, 64'(fetchError), 64'(expErr));
  endtask

  task automatic applyStimulus(input logic en, input logic adv, input logic br,
                               input logic [DW-1:0] tgt, input logic rdy, input logic [IW-1:0] data);
    enable           = en;
    advance          = adv;
    shouldTakeBranch = br;
    branchTarget     = tgt;
    memReady         = rdy;
    memData          = data;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered with the DUT in its request cycle; returns with the word delivered and held.
  task automatic fetchOnce(input int latency, input logic [IW-1:0] data);
    checkAll("request", 1'b1);
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), IW'($urandom));
    idleWait = 0;
    for (int i = 0; i <= latency; i++) begin
      tick();
      checkAll("wait", 1'b1);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    (i == latency), (i == latency) ? data : IW'($urandom));
      if (i != latency) begin
        idleWait++;
        if (idleWait >= TO) expErr = 1'b1;
      end
    end
    tick();
    expInstr = data;
    expValid = 1'b1;
    checkAll("hold", 1'b0);
  endtask

  // Entered in the held state; returns in the next request cycle.
  task automatic holdPhase(input int frozen, input int idleEn, input logic br, input logic [DW-1:0] tgt);
    for (int i = 0; i < frozen; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom), $urandom, 1'($urandom), IW'($urandom));
      tick();
      checkAll("frozen", 1'b0);
    end
    for (int i = 0; i < idleEn; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom), $urandom, 1'($urandom), IW'($urandom));
      tick();
      checkAll("hold_idle", 1'b0);
    end
    applyStimulus(1'b1, 1'b1, br, tgt, 1'($urandom), IW'($urandom));
    tick();
    expPc    = br ? tgt : expPc + 1'b1;
    expValid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    expPc    = RV;
    expInstr = '0;
    expValid = 1'b0;
    expErr   = 1'b0;
    #3;
    checkAll("reset", 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkAll("idle", 1'b0);
    tick();

    fetchOnce(0, 16'hA5C3);

    holdPhase(0, 1, 1'b1, 32'h10);
    fetchOnce($urandom_range(0, 3), IW'($urandom));
    holdPhase(0, 0, 1'b1, 32'h40);
    fetchOnce($urandom_range(0, 3), IW'($urandom));

    holdPhase(5, 0, 1'b0, $urandom);
    fetchOnce(1, IW'($urandom));

    holdPhase(0, 0, 1'b1, 32'hFFFF_FFFF);
    fetchOnce(0, IW'($urandom));
    holdPhase(0, 0, 1'b0, $urandom);
    fetchOnce(1, IW'($urandom));

    for (int n = 0; n < 24; n++) begin
      holdPhase($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), $urandom);
      fetchOnce($urandom_range(0, 6), IW'($urandom));
    end

    holdPhase(0, 0, 1'b0, $urandom);
    fetchOnce(300, IW'($urandom));
    for (int n = 0; n < 3; n++) begin
      holdPhase($urandom_range(0, 2), 0, 1'($urandom), $urandom);
      fetchOnce($urandom_range(0, 4), IW'($urandom));
    end

    // Reset lands mid-wait with memory ready; the word must never show up.
    holdPhase(0, 0, 1'b0, $urandom);
    checkAll("request", 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checkAll("wait", 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 16'hDEAD);
    #2;
    reset = 1'b0;
    #1;
    expPc    = RV;
    expInstr = '0;
    expValid = 1'b0;
    expErr   = 1'b0;
    checkAll("async_reset", 1'b0);
    tick();
    checkAll("in_reset", 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    #1;
    checkAll("idle_after_reset", 1'b0);
    tick();
    fetchOnce(2, 16'h1234);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
